// File: rtl/decode_sequencer_pkg.sv
// rtl/decode_sequencer_pkg.sv - shared state types and SRAM owner encoding
//
// Contents:
//   seq_state_type : top-level load/decode/display sequencer states
//   M1_state_type  : milestone-1 worker states (used by the M1 worker)
//   OWNER_*        : SRAM owner codes driven on owner_o
//   owner_of()     : SRAM owner implied by a sequencer state
package decode_sequencer_pkg;

    typedef enum logic [2:0] {
        S_SEQ_IDLE,
        S_SEQ_UART,
        S_SEQ_GAP,
        S_SEQ_M2,
        S_SEQ_M1,
        S_SEQ_VGA
    } seq_state_type;

    typedef enum logic [2:0] {
        S_M1_IDLE,
        S_M1_LEAD_IN,
        S_M1_COMMON,
        S_M1_LEAD_OUT
    } M1_state_type;

    localparam logic [1:0] OWNER_VGA  = 2'd0;
    localparam logic [1:0] OWNER_UART = 2'd1;
    localparam logic [1:0] OWNER_M2   = 2'd2;
    localparam logic [1:0] OWNER_M1   = 2'd3;

    // GAP has no owner of its own; the caller keeps the previous one.
    function automatic logic [1:0] owner_of(input seq_state_type s);
        case (s)
            S_SEQ_UART: owner_of = OWNER_UART;
            S_SEQ_M2:   owner_of = OWNER_M2;
            S_SEQ_M1:   owner_of = OWNER_M1;
            default:    owner_of = OWNER_VGA;
        endcase
    endfunction

endpackage

// File: rtl/decode_sequencer_sram_client_mux.sv
// rtl/decode_sequencer_sram_client_mux.sv - combinational four-client SRAM port mux
//
// Ports:
//   owner                     : selected client (OWNER_* encoding)
//   vga_addr                  : VGA read address (VGA never writes)
//   uart_/m2_/m1_ addr,wdata,we_n : write-capable client requests
//   sram_addr/sram_wdata/sram_we_n : muxed SRAM port
module sram_client_mux
    import decode_sequencer_pkg::*;
(
    input  logic [1:0]  owner,
    input  logic [17:0] vga_addr,
    input  logic [17:0] uart_addr,
    input  logic [15:0] uart_wdata,
    input  logic        uart_we_n,
    input  logic [17:0] m2_addr,
    input  logic [15:0] m2_wdata,
    input  logic        m2_we_n,
    input  logic [17:0] m1_addr,
    input  logic [15:0] m1_wdata,
    input  logic        m1_we_n,
    output logic [17:0] sram_addr,
    output logic [15:0] sram_wdata,
    output logic        sram_we_n
);

    always_comb begin
        sram_addr  = vga_addr;
        sram_wdata = 16'd0;
        sram_we_n  = 1'b1;
        case (owner)
            OWNER_UART: begin
                sram_addr  = uart_addr;
                sram_wdata = uart_wdata;
                sram_we_n  = uart_we_n;
            end
            OWNER_M2: begin
                sram_addr  = m2_addr;
                sram_wdata = m2_wdata;
                sram_we_n  = m2_we_n;
            end
            OWNER_M1: begin
                sram_addr  = m1_addr;
                sram_wdata = m1_wdata;
                sram_we_n  = m1_we_n;
            end
            default: begin
                sram_addr  = vga_addr;
                sram_wdata = 16'd0;
                sram_we_n  = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/decode_sequencer.sv
// rtl/decode_sequencer.sv - UART -> M2 -> M1 -> VGA sequencer with watchdog and SRAM arbitration
//
// Ports:
//   CLOCK_50_I, resetn            : clock, asynchronous active-low reset
//   start_i, skip_m2_i            : sequence request, M2 bypass (sampled at start)
//   uart_done_i/M2_done_i/M1_done_i : level completion flags from workers
//   *_addr_i/*_wdata_i/*_we_n_i   : per-client SRAM requests
//   uart_enable_o, M2_start_o, M1_start_o : worker controls
//   SRAM_address_o/SRAM_write_data_o/SRAM_we_n_o : muxed SRAM port
//   owner_o, busy_o, error_o      : status (error_o is the sticky watchdog flag)
module decode_sequencer
    import decode_sequencer_pkg::*;
#(
    parameter logic [25:0] TIMEOUT_CYCLES = 26'd50_000_000,
    parameter logic [25:0] GUARD_CYCLES   = 26'd2
)
(
    input  logic        CLOCK_50_I,
    input  logic        resetn,
    input  logic        start_i,
    input  logic        skip_m2_i,
    input  logic        uart_done_i,
    input  logic        M2_done_i,
    input  logic        M1_done_i,
    input  logic [17:0] uart_addr_i,
    input  logic [17:0] m2_addr_i,
    input  logic [17:0] m1_addr_i,
    input  logic [17:0] vga_addr_i,
    input  logic [15:0] uart_wdata_i,
    input  logic [15:0] m2_wdata_i,
    input  logic [15:0] m1_wdata_i,
    input  logic        uart_we_n_i,
    input  logic        m2_we_n_i,
    input  logic        m1_we_n_i,
    output logic        uart_enable_o,
    output logic        M2_start_o,
    output logic        M1_start_o,
    output logic [17:0] SRAM_address_o,
    output logic [15:0] SRAM_write_data_o,
    output logic        SRAM_we_n_o,
    output logic [1:0]  owner_o,
    output logic        busy_o,
    output logic        error_o
);

    seq_state_type state, state_d;
    seq_state_type next_worker, next_worker_d;
    logic [25:0]   phase_cnt;
    logic          skip_m2, skip_m2_d;
    logic          error_d;
    logic [1:0]    owner_d;
    logic          timeout;
    logic          guard_open;
    logic          mux_we_n;

    assign timeout    = (phase_cnt == TIMEOUT_CYCLES - 26'd1);
    // Workers may still show done from the previous run for a few cycles.
    assign guard_open = (phase_cnt >= GUARD_CYCLES);

    always_comb begin
        state_d       = state;
        next_worker_d = next_worker;
        skip_m2_d     = skip_m2;
        error_d       = error_o;
        owner_d       = owner_o;
        case (state)
            S_SEQ_IDLE, S_SEQ_VGA: begin
                if (start_i) begin
                    state_d   = S_SEQ_UART;
                    skip_m2_d = skip_m2_i;
                    error_d   = 1'b0;
                end
            end
            // Done is checked before timeout so a completion on the last
            // allowed cycle still counts.
            S_SEQ_UART: begin
                if (uart_done_i) begin
                    state_d       = S_SEQ_GAP;
                    next_worker_d = skip_m2 ? S_SEQ_M1 : S_SEQ_M2;
                end else if (timeout) begin
                    state_d = S_SEQ_IDLE;
                    error_d = 1'b1;
                end
            end
            S_SEQ_GAP: state_d = next_worker;
            S_SEQ_M2: begin
                if (M2_done_i && guard_open) begin
                    state_d       = S_SEQ_GAP;
                    next_worker_d = S_SEQ_M1;
                end else if (timeout) begin
                    state_d = S_SEQ_IDLE;
                    error_d = 1'b1;
                end
            end
            S_SEQ_M1: begin
                if (M1_done_i && guard_open) begin
                    state_d       = S_SEQ_GAP;
                    next_worker_d = S_SEQ_VGA;
                end else if (timeout) begin
                    state_d = S_SEQ_IDLE;
                    error_d = 1'b1;
                end
            end
            default: state_d = S_SEQ_IDLE;
        endcase
        // Through GAP the outgoing owner keeps the bus so the address is stable.
        if (state_d != S_SEQ_GAP)
            owner_d = owner_of(state_d);
    end

    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn) begin
            state       <= S_SEQ_IDLE;
            next_worker <= S_SEQ_IDLE;
            phase_cnt   <= 26'd0;
            skip_m2     <= 1'b0;
            error_o     <= 1'b0;
            owner_o     <= OWNER_VGA;
        end else begin
            state       <= state_d;
            next_worker <= next_worker_d;
            skip_m2     <= skip_m2_d;
            error_o     <= error_d;
            owner_o     <= owner_d;
            if (state_d != state)
                phase_cnt <= 26'd0;
            else if (state == S_SEQ_UART || state == S_SEQ_M2 || state == S_SEQ_M1)
                phase_cnt <= phase_cnt + 26'd1;
        end
    end

    // Start pulses mark a worker's first cycle; a timed-out phase goes to
    // IDLE, so no pulse follows an abort.
    assign uart_enable_o = (state == S_SEQ_UART);
    assign M2_start_o    = (state == S_SEQ_M2) && (phase_cnt == 26'd0);
    assign M1_start_o    = (state == S_SEQ_M1) && (phase_cnt == 26'd0);
    assign busy_o        = (state != S_SEQ_IDLE) && (state != S_SEQ_VGA);

    sram_client_mux u_mux (
        .owner      (owner_o),
        .vga_addr   (vga_addr_i),
        .uart_addr  (uart_addr_i),
        .uart_wdata (uart_wdata_i),
        .uart_we_n  (uart_we_n_i),
        .m2_addr    (m2_addr_i),
        .m2_wdata   (m2_wdata_i),
        .m2_we_n    (m2_we_n_i),
        .m1_addr    (m1_addr_i),
        .m1_wdata   (m1_wdata_i),
        .m1_we_n    (m1_we_n_i),
        .sram_addr  (SRAM_address_o),
        .sram_wdata (SRAM_write_data_o),
        .sram_we_n  (mux_we_n)
    );

    assign SRAM_we_n_o = mux_we_n | (state == S_SEQ_GAP) | ~resetn;

endmodule

// File: tb/tb_decode_sequencer.sv
// tb/tb_decode_sequencer.sv - randomized self-checking bench for decode_sequencer
module tb_decode_sequencer;

    localparam int TO = 100;
    localparam int G  = 2;
    localparam int P_IDLE = 0, P_UART = 1, P_GAP = 2, P_M2 = 3, P_M1 = 4, P_VGA = 5;

    logic        CLOCK_50_I = 1'b0;
    logic        resetn;
    logic        start_i, skip_m2_i, uart_done_i, M2_done_i, M1_done_i;
    logic [17:0] uart_addr_i, m2_addr_i, m1_addr_i, vga_addr_i;
    logic [15:0] uart_wdata_i, m2_wdata_i, m1_wdata_i;
    logic        uart_we_n_i, m2_we_n_i, m1_we_n_i;
    logic        uart_enable_o, M2_start_o, M1_start_o;
    logic [17:0] SRAM_address_o;
    logic [15:0] SRAM_write_data_o;
    logic        SRAM_we_n_o;
    logic [1:0]  owner_o;
    logic        busy_o, error_o;

    always #10 CLOCK_50_I = ~CLOCK_50_I;

    decode_sequencer #(.TIMEOUT_CYCLES(26'd100), .GUARD_CYCLES(26'd2)) dut (
        .CLOCK_50_I(CLOCK_50_I), .resetn(resetn), .start_i(start_i), .skip_m2_i(skip_m2_i),
        .uart_done_i(uart_done_i), .M2_done_i(M2_done_i), .M1_done_i(M1_done_i),
        .uart_addr_i(uart_addr_i), .m2_addr_i(m2_addr_i), .m1_addr_i(m1_addr_i),
        .vga_addr_i(vga_addr_i), .uart_wdata_i(uart_wdata_i), .m2_wdata_i(m2_wdata_i),
        .m1_wdata_i(m1_wdata_i), .uart_we_n_i(uart_we_n_i), .m2_we_n_i(m2_we_n_i),
        .m1_we_n_i(m1_we_n_i), .uart_enable_o(uart_enable_o), .M2_start_o(M2_start_o),
        .M1_start_o(M1_start_o), .SRAM_address_o(SRAM_address_o),
        .SRAM_write_data_o(SRAM_write_data_o), .SRAM_we_n_o(SRAM_we_n_o),
        .owner_o(owner_o), .busy_o(busy_o), .error_o(error_o)
    );

    // Reference model: phase name, cycles spent in it, and the sequence plan.
    int m_phase, m_age, m_next, m_owner;
    bit m_skip, m_err;
    int vec_cnt = 0, err_cnt = 0;
    int m2_pulses = 0;
    bit hold_clients = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = P_IDLE; m_age = 0; m_next = P_IDLE; m_owner = 0; m_skip = 1'b0; m_err = 1'b0;
    endtask

    // One worker phase: done (after guard) moves on, else abort on last cycle.
    task automatic worker_step(input bit done, input int guard, input int nxt);
        if (done && m_age >= guard) begin
            m_phase = P_GAP; m_next = nxt; m_age = 0;
        end else if (m_age == TO - 1) begin
            m_phase = P_IDLE; m_err = 1'b1; m_owner = 0; m_age = 0;
        end else begin
            m_age++;
        end
    endtask

    task automatic model_step();
        case (m_phase)
            P_IDLE, P_VGA: if (start_i) begin
                m_phase = P_UART; m_age = 0; m_skip = skip_m2_i; m_err = 1'b0; m_owner = 1;
            end
            P_UART: worker_step(uart_done_i, 0, m_skip ? P_M1 : P_M2);
            P_GAP: begin
                m_phase = m_next; m_age = 0;
                m_owner = (m_next == P_M2) ? 2 : (m_next == P_M1) ? 3 : 0;
            end
            P_M2: worker_step(M2_done_i, G, P_M1);
            P_M1: worker_step(M1_done_i, G, P_VGA);
            default: m_phase = P_IDLE;
        endcase
    endtask

    task automatic check_all();
        logic [17:0] ea; logic [15:0] ed; logic ew;
        case (m_owner)
            1: begin ea = uart_addr_i; ed = uart_wdata_i; ew = uart_we_n_i; end
            2: begin ea = m2_addr_i;   ed = m2_wdata_i;   ew = m2_we_n_i;   end
            3: begin ea = m1_addr_i;   ed = m1_wdata_i;   ew = m1_we_n_i;   end
            default: begin ea = vga_addr_i; ed = 16'd0; ew = 1'b1; end
        endcase
        if (m_phase == P_GAP) ew = 1'b1;
        check_val("owner",    32'(owner_o),       32'(m_owner));
        check_val("busy",     32'(busy_o),        32'(m_phase >= P_UART && m_phase <= P_M1));
        check_val("uart_en",  32'(uart_enable_o), 32'(m_phase == P_UART));
        check_val("m2_start", 32'(M2_start_o),    32'(m_phase == P_M2 && m_age == 0));
        check_val("m1_start", 32'(M1_start_o),    32'(m_phase == P_M1 && m_age == 0));
        check_val("error",    32'(error_o),       32'(m_err));
        check_val("addr",     32'(SRAM_address_o),    32'(ea));
        check_val("wdata",    32'(SRAM_write_data_o), 32'(ed));
        check_val("we_n",     32'(SRAM_we_n_o),       32'(ew));
    endtask

    task automatic randomize_clients();
        if (!hold_clients) begin
            uart_addr_i = 18'($urandom); m2_addr_i = 18'($urandom);
            m1_addr_i = 18'($urandom);   vga_addr_i = 18'($urandom);
            uart_wdata_i = 16'($urandom); m2_wdata_i = 16'($urandom); m1_wdata_i = 16'($urandom);
            uart_we_n_i = 1'($urandom); m2_we_n_i = 1'($urandom); m1_we_n_i = 1'($urandom);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK_50_I);
        if (!resetn) model_reset(); else model_step();
        #1;
        check_all();
        if (M2_start_o) m2_pulses++;
        @(negedge CLOCK_50_I);
        randomize_clients();
    endtask

    task automatic wait_phase(input int ph, input int age, input string tag);
        for (int i = 0; i < 300 && !(m_phase == ph && m_age == age); i++) tick();
        check_val({tag, "_reached"}, 32'(m_phase == ph && m_age == age), 32'd1);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        #1;
        model_reset();
        check_all();
        check_val("rst_we_n", 32'(SRAM_we_n_o), 32'd1);
        tick();
        resetn = 1'b1;
    endtask

    task automatic pulse_start(input logic skip);
        skip_m2_i = skip; start_i = 1'b1;
        tick();
        start_i = 1'b0; skip_m2_i = 1'b0;
    endtask

    initial begin
        resetn = 1'b0; start_i = 1'b0; skip_m2_i = 1'b0;
        uart_done_i = 1'b0; M2_done_i = 1'b0; M1_done_i = 1'b0;
        randomize_clients();
        model_reset();
        #1;
        check_all();
        tick(); tick();
        resetn = 1'b1;

        // Full sequence with UART done on its 10th cycle.
        pulse_start(1'b0);
        check_val("s1_uart_en", 32'(uart_enable_o), 32'd1);
        wait_phase(P_UART, 9, "s1_uart9");
        uart_done_i = 1'b1; tick(); uart_done_i = 1'b0;
        check_val("s1_gap_we_n", 32'(SRAM_we_n_o), 32'd1);
        check_val("s1_gap_no_start", 32'(M2_start_o), 32'd0);
        tick();
        check_val("s1_m2_start", 32'(M2_start_o), 32'd1);
        check_val("s1_owner_m2", 32'(owner_o), 32'd2);
        M2_done_i = 1'b1; tick();
        check_val("s1_m2_pulse_end", 32'(M2_start_o), 32'd0);
        wait_phase(P_GAP, 0, "s1_m2_gap");
        M2_done_i = 1'b0;
        // Stale M1 done across the guard window, then dropped.
        M1_done_i = 1'b1; tick(); tick();
        M1_done_i = 1'b0;
        wait_phase(P_M1, 5, "s1_m1_5");
        start_i = 1'b1; tick(); start_i = 1'b0;
        check_val("s1_start_ignored", 32'(uart_enable_o), 32'd0);
        wait_phase(P_M1, 20, "s1_m1_20");
        check_val("s1_still_m1", 32'(owner_o), 32'd3);
        M1_done_i = 1'b1; tick(); M1_done_i = 1'b0;
        tick();
        check_val("s1_vga_busy", 32'(busy_o), 32'd0);
        for (int i = 0; i < 10; i++) tick();
        check_val("s1_vga_owner", 32'(owner_o), 32'd0);

        // Skip M2, restart from VGA, directed M1 write.
        m2_pulses = 0;
        pulse_start(1'b1);
        wait_phase(P_UART, 3, "s2_uart3");
        uart_done_i = 1'b1; tick(); uart_done_i = 1'b0;
        hold_clients = 1'b1;
        m1_addr_i = 18'd146944; m1_we_n_i = 1'b0; m1_wdata_i = 16'hBEEF;
        tick();
        check_val("s2_m1_start", 32'(M1_start_o), 32'd1);
        check_val("s2_m1_addr", 32'(SRAM_address_o), 32'd146944);
        check_val("s2_m1_we_n", 32'(SRAM_we_n_o), 32'd0);
        wait_phase(P_M1, 4, "s2_m1_4");
        M1_done_i = 1'b1; tick(); M1_done_i = 1'b0;
        check_val("s2_gap_we_n", 32'(SRAM_we_n_o), 32'd1);
        tick();
        check_val("s2_vga_we_n", 32'(SRAM_we_n_o), 32'd1);
        hold_clients = 1'b0;
        check_val("s2_no_m2_pulse", 32'(m2_pulses), 32'd0);

        // Done on the final UART cycle wins; M2 then times out.
        pulse_start(1'b0);
        wait_phase(P_UART, TO - 1, "s3_uart_last");
        uart_done_i = 1'b1; tick(); uart_done_i = 1'b0;
        check_val("s3_done_wins", 32'(error_o), 32'd0);
        wait_phase(P_M2, TO - 1, "s3_m2_last");
        tick();
        check_val("s3_timeout_err", 32'(error_o), 32'd1);
        check_val("s3_timeout_idle", 32'(busy_o), 32'd0);
        for (int i = 0; i < 5; i++) tick();
        check_val("s3_err_sticky", 32'(error_o), 32'd1);
        pulse_start(1'b0);
        check_val("s3_err_clear", 32'(error_o), 32'd0);
        tick(); tick();
        do_reset();

        // Random traffic, alternating fast and slow workers to provoke aborts.
        for (int i = 0; i < 3000; i++) begin
            int rate;
            rate = ((i / 400) % 2 == 0) ? 7 : 250;
            start_i     = ($urandom_range(0, 15) == 0);
            skip_m2_i   = 1'($urandom);
            uart_done_i = ($urandom_range(0, rate) == 0);
            M2_done_i   = ($urandom_range(0, rate) == 0);
            M1_done_i   = ($urandom_range(0, rate) == 0);
            if ($urandom_range(0, 700) == 0) do_reset();
            else tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
